snow64_pipe_stage_if_id_fetch_queue: RTL and testbench

//  Parametrised fetch front end for the Snow64 IF/ID stage. Owns the fetch PC.

---
 rtl/snow64_pipe_stage_if_id_fetch_queue.sv | 117 +++++++++++
 tb/tb_snow64_pipe_stage_if_id_fetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_pipe_stage_if_id_fetch_queue.sv
// Snow64 IF/ID fetch front end: owns the fetch PC, issues credit-limited icache
// requests and buffers returned words with their PCs for decode.
module snow64_pipe_stage_if_id_fetch_queue #(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    FETCH_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [ADDR_WIDTH-1:0]  icache_req_addr,
    input  logic                   icache_resp_valid,
    input  logic [INSTR_WIDTH-1:0] icache_resp_instr,
    input  logic                   ex_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  ex_redirect_pc,
    input  logic                   ctrl_stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   out_fetch_busy
);

    localparam int CW = $clog2(FETCH_DEPTH + 1);
    localparam int PW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
    localparam logic [CW:0]           DEPTH_X  = (CW + 1)'(FETCH_DEPTH);
    localparam logic [PW-1:0]         LAST_PTR = PW'(FETCH_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    logic [INSTR_WIDTH-1:0] q_instr [FETCH_DEPTH];
    logic [ADDR_WIDTH-1:0]  q_pc    [FETCH_DEPTH];

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    logic [CW:0]   in_use;
    logic [CW-1:0] outstanding_dec;
    logic          req_ok;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;
    logic          head_valid;

    // Credits cover both in-flight requests and buffered words, so the queue never overflows.
    assign in_use          = {1'b0, outstanding} + {1'b0, count};
    assign req_ok          = !rst && !ex_redirect_valid && (in_use < DEPTH_X);
    assign accept          = req_ok && icache_req_ready;
    assign resp            = icache_resp_valid && !rst;
    assign outstanding_dec = outstanding - CW'(resp);
    assign push            = resp && (drop == '0) && !ex_redirect_valid;
    assign head_valid      = (count != '0);
    assign pop             = head_valid && out_ready && !ctrl_stall && !ex_redirect_valid;

    assign icache_req_valid = req_ok;
    assign icache_req_addr  = rst ? '0 : fetch_pc;
    assign out_valid        = !rst && head_valid;
    assign out_instr        = out_valid ? q_instr[rd_ptr] : '0;
    assign out_pc           = out_valid ? q_pc[rd_ptr] : '0;
    assign out_fetch_busy   = !rst && (outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_dec + CW'(accept);
            if (ex_redirect_valid) begin
                // Everything still in flight after this cycle's response is stale.
                fetch_pc <= ex_redirect_pc;
                resp_pc  <= ex_redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding_dec;
            end else begin
                if (accept) fetch_pc <= fetch_pc + STEP;
                if (push) begin
                    resp_pc <= resp_pc + STEP;
                    wr_ptr  <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                if (resp && (drop != '0)) drop <= drop - CW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= icache_resp_instr;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_snow64_pipe_stage_if_id_fetch_queue.sv
// Directed bench for the fetch queue with a fixed-latency in-order icache model.
module tb_snow64_pipe_stage_if_id_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [63:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_instr;
    logic        ex_redirect_valid;
    logic [63:0] ex_redirect_pc;
    logic        ctrl_stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fetch_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [63:0] pend_addr[$];
    int          pend_due[$];

    snow64_pipe_stage_if_id_fetch_queue #(
        .INSTR_WIDTH(32), .ADDR_WIDTH(64), .FETCH_DEPTH(4),
        .RESET_PC(64'h1000), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_addr(icache_req_addr),
        .icache_resp_valid(icache_resp_valid), .icache_resp_instr(icache_resp_instr),
        .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
        .ctrl_stall(ctrl_stall),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_fetch_busy(out_fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive this cycle's icache response, then wait for outputs to settle.
    task automatic cyc_begin();
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            icache_resp_valid = 1'b0;
            icache_resp_instr = '0;
        end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            icache_resp_valid = 1'b1;
            icache_resp_instr = instr_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            icache_resp_valid = 1'b0;
            icache_resp_instr = '0;
        end
        @(negedge clk);
    endtask

    task automatic cyc_end();
        if (!rst && icache_req_valid && icache_req_ready) begin
            pend_addr.push_back(icache_req_addr);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        icache_req_ready = 1'b0;
        ex_redirect_valid = 1'b0;
        ex_redirect_pc = '0;
        ctrl_stall = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin
            cyc_begin();
            cyc_end();
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1;
        icache_req_ready = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_instr = '0;
        ex_redirect_valid = 1'b0;
        ex_redirect_pc = '0;
        ctrl_stall = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Outputs while in reset
        icache_req_ready = 1'b1;
        out_ready = 1'b1;
        cyc_begin();
        chk("rst_req_valid", 64'(icache_req_valid), 64'd0);
        chk("rst_req_addr", icache_req_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(out_fetch_busy), 64'd0);
        cyc_end();

        // Test 1: streaming
        do_reset();
        lat = 1;
        icache_req_ready = 1'b1;
        out_ready = 1'b1;
        cyc_begin();
        chk("t1_c0_req_valid", 64'(icache_req_valid), 64'd1);
        chk("t1_c0_addr", icache_req_addr, 64'h1000);
        chk("t1_c0_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c0_busy", 64'(out_fetch_busy), 64'd0);
        cyc_end();
        cyc_begin();
        chk("t1_c1_addr", icache_req_addr, 64'h1004);
        chk("t1_c1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_c1_busy", 64'(out_fetch_busy), 64'd1);
        cyc_end();
        for (int c = 2; c < 8; c++) begin
            cyc_begin();
            chk("t1_out_valid", 64'(out_valid), 64'd1);
            chk("t1_out_pc", out_pc, 64'h1000 + 64'(4 * (c - 2)));
            chk("t1_out_instr", 64'(out_instr), 64'(instr_of(64'h1000 + 64'(4 * (c - 2)))));
            chk("t1_addr", icache_req_addr, 64'h1000 + 64'(4 * c));
            cyc_end();
        end

        // Test 2: backpressure fills the queue, then drains through the pointer wrap
        do_reset();
        icache_req_ready = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc_begin();
            chk("t2_fill_req_valid", 64'(icache_req_valid), 64'd1);
            chk("t2_fill_addr", icache_req_addr, 64'h1000 + 64'(4 * c));
            cyc_end();
        end
        for (int c = 4; c < 7; c++) begin
            cyc_begin();
            chk("t2_full_req_valid", 64'(icache_req_valid), 64'd0);
            chk("t2_full_out_pc", out_pc, 64'h1000);
            cyc_end();
        end
        cyc_begin();
        chk("t2_c7_busy", 64'(out_fetch_busy), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("t2_c7_out_pc", out_pc, 64'h1000);
        chk("t2_c7_req_valid", 64'(icache_req_valid), 64'd0);
        cyc_end();
        cyc_begin();
        chk("t2_c8_req_valid", 64'(icache_req_valid), 64'd1);
        chk("t2_c8_addr", icache_req_addr, 64'h1010);
        chk("t2_c8_out_pc", out_pc, 64'h1004);
        cyc_end();
        for (int c = 9; c < 13; c++) begin
            cyc_begin();
            chk("t2_drain_valid", 64'(out_valid), 64'd1);
            chk("t2_drain_pc", out_pc, 64'h1004 + 64'(4 * (c - 8)));
            chk("t2_drain_instr", 64'(out_instr), 64'(instr_of(64'h1004 + 64'(4 * (c - 8)))));
            cyc_end();
        end

        // Test 3: latency 3, redirect with two fetches in flight
        do_reset();
        lat = 3;
        icache_req_ready = 1'b1;
        out_ready = 1'b1;
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        ex_redirect_valid = 1'b1;
        ex_redirect_pc = 64'h2000;
        cyc_begin();
        chk("t3_redir_req_valid", 64'(icache_req_valid), 64'd0);
        chk("t3_redir_busy", 64'(out_fetch_busy), 64'd1);
        cyc_end();
        ex_redirect_valid = 1'b0;
        ex_redirect_pc = '0;
        cyc_begin();
        chk("t3_c3_addr", icache_req_addr, 64'h2000);
        chk("t3_c3_req_valid", 64'(icache_req_valid), 64'd1);
        cyc_end();
        for (int c = 4; c < 7; c++) begin
            cyc_begin();
            chk("t3_stale_out_valid", 64'(out_valid), 64'd0);
            cyc_end();
        end
        cyc_begin();
        chk("t3_c7_out_valid", 64'(out_valid), 64'd1);
        chk("t3_c7_out_pc", out_pc, 64'h2000);
        chk("t3_c7_out_instr", 64'(out_instr), 64'(instr_of(64'h2000)));
        cyc_end();
        cyc_begin();
        chk("t3_c8_out_pc", out_pc, 64'h2004);
        cyc_end();

        // Test 4: redirect, pop and response in the same cycle
        do_reset();
        lat = 1;
        icache_req_ready = 1'b1;
        out_ready = 1'b1;
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        ex_redirect_valid = 1'b1;
        ex_redirect_pc = 64'h3000;
        cyc_begin();
        chk("t4_c2_resp_present", 64'(icache_resp_valid), 64'd1);
        chk("t4_c2_out_pc", out_pc, 64'h1000);
        cyc_end();
        ex_redirect_valid = 1'b0;
        ex_redirect_pc = '0;
        cyc_begin();
        chk("t4_c3_out_valid", 64'(out_valid), 64'd0);
        chk("t4_c3_addr", icache_req_addr, 64'h3000);
        chk("t4_c3_busy", 64'(out_fetch_busy), 64'd0);
        cyc_end();
        cyc_begin();
        chk("t4_c4_out_valid", 64'(out_valid), 64'd0);
        cyc_end();
        cyc_begin();
        chk("t4_c5_out_pc", out_pc, 64'h3000);
        cyc_end();
        cyc_begin();
        chk("t4_c6_out_pc", out_pc, 64'h3004);
        cyc_end();

        // Test 5: control stall freezes the head
        do_reset();
        icache_req_ready = 1'b1;
        out_ready = 1'b1;
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        ctrl_stall = 1'b1;
        for (int c = 2; c < 5; c++) begin
            cyc_begin();
            chk("t5_stall_valid", 64'(out_valid), 64'd1);
            chk("t5_stall_pc", out_pc, 64'h1000);
            chk("t5_stall_instr", 64'(out_instr), 64'(instr_of(64'h1000)));
            cyc_end();
        end
        ctrl_stall = 1'b0;
        cyc_begin();
        chk("t5_c5_pc", out_pc, 64'h1000);
        cyc_end();
        cyc_begin();
        chk("t5_c6_pc", out_pc, 64'h1004);
        cyc_end();

        // Test 6: reset pulse with three words buffered
        do_reset();
        icache_req_ready = 1'b1;
        out_ready = 1'b0;
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        cyc_begin();
        chk("t6_c3_out_pc", out_pc, 64'h1000);
        cyc_end();
        rst = 1'b1;
        cyc_begin();
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_out_pc", out_pc, 64'd0);
        chk("t6_rst_req_valid", 64'(icache_req_valid), 64'd0);
        chk("t6_rst_addr", icache_req_addr, 64'd0);
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        chk("t6_after_out_valid", 64'(out_valid), 64'd0);
        chk("t6_after_req_valid", 64'(icache_req_valid), 64'd1);
        chk("t6_after_addr", icache_req_addr, 64'h1000);
        chk("t6_after_busy", 64'(out_fetch_busy), 64'd0);
        cyc_end();
        cyc_begin(); cyc_end();
        cyc_begin();
        chk("t6_restart_pc", out_pc, 64'h1000);
        cyc_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
